// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline front end and pipeline_hazard_ctrl.
// master: pipeline side that raises requests and consumes stall/flush enables.
// slave:  the hazard controller itself.
// Signals: req_i, stall_mask_i, flush_mask_i, trap_req_i, stage_valid_i, clr_cnt_i,
//          cnt_sel_i (toward controller); stall_o, flush_o, win_valid_o, win_id_o,
//          redirect_o, drain_busy_o, cnt_o, deadlock_o (from controller).
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned STAGES = 6,
    parameter int unsigned NREQ   = 8,
    parameter int unsigned CNT_W  = 32
);
    localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req_i;
    logic [NREQ*STAGES-1:0] stall_mask_i;
    logic [NREQ*STAGES-1:0] flush_mask_i;
    logic                   trap_req_i;
    logic [STAGES-1:0]      stage_valid_i;
    logic                   clr_cnt_i;
    logic [ID_W-1:0]        cnt_sel_i;
    logic [STAGES-1:0]      stall_o;
    logic [STAGES-1:0]      flush_o;
    logic                   win_valid_o;
    logic [ID_W-1:0]        win_id_o;
    logic                   redirect_o;
    logic                   drain_busy_o;
    logic [CNT_W-1:0]       cnt_o;
    logic                   deadlock_o;

    modport master (
        output req_i, stall_mask_i, flush_mask_i, trap_req_i, stage_valid_i,
               clr_cnt_i, cnt_sel_i,
        input  stall_o, flush_o, win_valid_o, win_id_o, redirect_o,
               drain_busy_o, cnt_o, deadlock_o
    );

    modport slave (
        input  req_i, stall_mask_i, flush_mask_i, trap_req_i, stage_valid_i,
               clr_cnt_i, cnt_sel_i,
        output stall_o, flush_o, win_valid_o, win_id_o, redirect_o,
               drain_busy_o, cnt_o, deadlock_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush arbiter for an in-order pipeline: priority hazard arbitration,
// post-reset flush window, trap drain/redirect FSM, saturating per-channel
// stall counters and a sticky PC-stall deadlock watchdog.
// Ports: clk, rst_n (async active-low), bus (pipeline_hazard_ctrl_if.slave).
module pipeline_hazard_ctrl #(
    parameter int unsigned       STAGES         = 6,
    parameter int unsigned       NREQ           = 8,
    parameter int unsigned       CNT_W          = 32,
    parameter int unsigned       RST_FLUSH      = 2,
    parameter int unsigned       TIMEOUT        = 1024,
    parameter logic [STAGES-1:0] DRAIN_STALL    = STAGES'(6'b000011),
    parameter logic [STAGES-1:0] DRAIN_BUBBLE   = STAGES'(6'b000100),
    parameter logic [STAGES-1:0] DRAIN_WAIT     = STAGES'(6'b111000),
    parameter logic [STAGES-1:0] REDIRECT_FLUSH = STAGES'(6'b001110)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int unsigned ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned INIT_W = $clog2(RST_FLUSH + 1);
    localparam int unsigned RUN_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_IDLE     = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [INIT_W-1:0] init_cnt;
    logic              trap_pend;
    logic              raw_valid;
    logic [ID_W-1:0]   raw_id;
    logic [STAGES-1:0] ws, wf;
    logic [CNT_W-1:0]  cnt_q [NREQ];
    logic [RUN_W-1:0]  run_cnt;
    logic              deadlock_q;
    logic              cnt_inc;

    // Priority pick: later (higher-index) hits overwrite earlier ones.
    always_comb begin
        raw_valid = 1'b0;
        raw_id    = '0;
        ws        = '0;
        wf        = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (bus.req_i[k]) begin
                raw_valid = 1'b1;
                raw_id    = ID_W'(k);
                ws        = bus.stall_mask_i[k*STAGES +: STAGES];
                wf        = bus.flush_mask_i[k*STAGES +: STAGES];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:     if (init_cnt <= INIT_W'(1)) state_nxt = ST_IDLE;
            ST_IDLE:     if (bus.trap_req_i || trap_pend) state_nxt = ST_DRAIN;
            ST_DRAIN:    if ((bus.stage_valid_i & DRAIN_WAIT) == '0) state_nxt = ST_REDIRECT;
            ST_REDIRECT: state_nxt = ST_IDLE;
            default:     state_nxt = ST_INIT;
        endcase
    end

    // Output decode
    always_comb begin
        bus.stall_o      = '0;
        bus.flush_o      = '0;
        bus.win_valid_o  = 1'b0;
        bus.win_id_o     = '0;
        bus.redirect_o   = 1'b0;
        bus.drain_busy_o = 1'b0;
        case (state)
            ST_INIT: bus.flush_o = '1;
            ST_IDLE: begin
                bus.stall_o     = ws;
                bus.flush_o     = wf;
                bus.win_valid_o = raw_valid;
                bus.win_id_o    = raw_id;
            end
            ST_DRAIN: begin
                bus.stall_o      = ws | DRAIN_STALL;
                bus.flush_o      = (wf | DRAIN_BUBBLE) & ~DRAIN_STALL;
                bus.win_valid_o  = raw_valid;
                bus.win_id_o     = raw_id;
                bus.drain_busy_o = 1'b1;
            end
            ST_REDIRECT: begin
                bus.flush_o    = REDIRECT_FLUSH;
                bus.redirect_o = 1'b1;
            end
            default: bus.flush_o = '1;
        endcase
    end

    // Post-reset flush window countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     init_cnt <= INIT_W'(RST_FLUSH);
        else if (state == ST_INIT && init_cnt != '0)    init_cnt <= init_cnt - INIT_W'(1);
    end

    // One-deep trap pending: consumed on any IDLE cycle, extra traps dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  trap_pend <= 1'b0;
        else if (state == ST_IDLE)   trap_pend <= 1'b0;
        else if (bus.trap_req_i)     trap_pend <= 1'b1;
    end

    // win_valid_o is only asserted in IDLE/DRAIN, so it also gates by state
    assign cnt_inc = bus.win_valid_o && (ws != '0);

    // Saturating stall-cycle counters, clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
        end else if (bus.clr_cnt_i) begin
            for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
        end else if (cnt_inc && cnt_q[raw_id] != '1) begin
            cnt_q[raw_id] <= cnt_q[raw_id] + CNT_W'(1);
        end
    end

    assign bus.cnt_o = (32'(bus.cnt_sel_i) < NREQ) ? cnt_q[bus.cnt_sel_i] : '0;

    // Watchdog on consecutive PC stalls; flag is sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt    <= '0;
            deadlock_q <= 1'b0;
        end else if (bus.stall_o[0]) begin
            if (run_cnt != RUN_W'(TIMEOUT)) run_cnt <= run_cnt + RUN_W'(1);
            if (run_cnt >= RUN_W'(TIMEOUT - 1)) deadlock_q <= 1'b1;
        end else begin
            run_cnt <= '0;
        end
    end

    assign bus.deadlock_o = deadlock_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (CNT_W=3, TIMEOUT=16, other defaults).
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.STAGES(6), .NREQ(8), .CNT_W(3)) bus ();

    pipeline_hazard_ctrl #(.CNT_W(3), .TIMEOUT(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       trap;
        logic [5:0] valid;
        logic [5:0] es;
        logic [5:0] ef;
        logic       ewv;
        logic [2:0] eid;
        logic       er;
        logic       eb;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [7:0] req, input logic trap,
                       input logic [5:0] valid, input logic [5:0] es, input logic [5:0] ef,
                       input logic ewv, input logic [2:0] eid, input logic er, input logic eb);
        vq.push_back('{rst, req, trap, valid, es, ef, ewv, eid, er, eb});
    endtask

    initial begin
        bus.req_i         = '0;
        bus.stall_mask_i  = '0;
        bus.flush_mask_i  = '0;
        bus.trap_req_i    = 1'b0;
        bus.stage_valid_i = '0;
        bus.clr_cnt_i     = 1'b0;
        bus.cnt_sel_i     = '0;
        bus.stall_mask_i[0*6 +: 6] = 6'b000111;
        bus.flush_mask_i[0*6 +: 6] = 6'b001000;
        bus.stall_mask_i[2*6 +: 6] = 6'b000100;
        bus.stall_mask_i[3*6 +: 6] = 6'b000010;
        bus.flush_mask_i[3*6 +: 6] = 6'b001110;
        bus.stall_mask_i[5*6 +: 6] = 6'b000001;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        //   rst req    trap valid      stall      flush      wv id  red busy
        add(0, 8'h08, 0, 6'b000000, 6'b000000, 6'b111111, 0, 0, 0, 0); // in reset
        add(1, 8'h08, 0, 6'b000000, 6'b000000, 6'b111111, 0, 0, 0, 0); // INIT 1
        add(1, 8'h08, 0, 6'b000000, 6'b000000, 6'b111111, 0, 0, 0, 0); // INIT 2
        add(1, 8'h08, 0, 6'b000000, 6'b000010, 6'b001110, 1, 3, 0, 0); // IDLE ch3
        add(1, 8'h09, 0, 6'b000000, 6'b000010, 6'b001110, 1, 3, 0, 0); // ch3 beats ch0
        add(1, 8'h01, 0, 6'b000000, 6'b000111, 6'b001000, 1, 0, 0, 0); // ch0 alone
        add(1, 8'h00, 0, 6'b000000, 6'b000000, 6'b000000, 0, 0, 0, 0); // no winner
        add(1, 8'h00, 1, 6'b111000, 6'b000000, 6'b000000, 0, 0, 0, 0); // trap, IDLE decode
        add(1, 8'h00, 0, 6'b110000, 6'b000011, 6'b000100, 0, 0, 0, 1); // DRAIN 1
        add(1, 8'h08, 0, 6'b100000, 6'b000011, 6'b001100, 1, 3, 0, 1); // DRAIN 2 + ch3
        add(1, 8'h00, 0, 6'b000000, 6'b000011, 6'b000100, 0, 0, 0, 1); // DRAIN 3, empty
        add(1, 8'h08, 0, 6'b000000, 6'b000000, 6'b001110, 0, 0, 1, 0); // REDIRECT
        add(1, 8'h00, 0, 6'b000000, 6'b000000, 6'b000000, 0, 0, 0, 0); // IDLE
        add(1, 8'h00, 1, 6'b111000, 6'b000000, 6'b000000, 0, 0, 0, 0); // trap A
        add(1, 8'h00, 1, 6'b111000, 6'b000011, 6'b000100, 0, 0, 0, 1); // DRAIN, trap B pends
        add(1, 8'h00, 1, 6'b000000, 6'b000011, 6'b000100, 0, 0, 0, 1); // DRAIN, trap C dropped
        add(1, 8'h00, 0, 6'b000000, 6'b000000, 6'b001110, 0, 0, 1, 0); // REDIRECT
        add(1, 8'h00, 0, 6'b000000, 6'b000000, 6'b000000, 0, 0, 0, 0); // IDLE gap
        add(1, 8'h00, 0, 6'b000000, 6'b000011, 6'b000100, 0, 0, 0, 1); // second DRAIN
        add(1, 8'h00, 0, 6'b000000, 6'b000000, 6'b001110, 0, 0, 1, 0); // REDIRECT
        add(1, 8'h00, 0, 6'b000000, 6'b000000, 6'b000000, 0, 0, 0, 0); // IDLE
        add(1, 8'h00, 0, 6'b000000, 6'b000000, 6'b000000, 0, 0, 0, 0); // no third drain

        foreach (vq[i]) begin
            @(negedge clk);
            rst_n             = vq[i].rst;
            bus.req_i         = vq[i].req;
            bus.trap_req_i    = vq[i].trap;
            bus.stage_valid_i = vq[i].valid;
            #1;
            chk($sformatf("v%0d stall", i), 32'(bus.stall_o), 32'(vq[i].es));
            chk($sformatf("v%0d flush", i), 32'(bus.flush_o), 32'(vq[i].ef));
            chk($sformatf("v%0d win_valid", i), 32'(bus.win_valid_o), 32'(vq[i].ewv));
            chk($sformatf("v%0d win_id", i), 32'(bus.win_id_o), 32'(vq[i].eid));
            chk($sformatf("v%0d redirect", i), 32'(bus.redirect_o), 32'(vq[i].er));
            chk($sformatf("v%0d drain_busy", i), 32'(bus.drain_busy_o), 32'(vq[i].eb));
            if (i == 0) begin
                chk("reset deadlock", 32'(bus.deadlock_o), 32'd0);
                chk("reset cnt", 32'(bus.cnt_o), 32'd0);
            end
        end

        // Counters accumulated by the table: ch3 three cycles, ch0 one cycle
        @(negedge clk);
        bus.req_i = '0;
        bus.cnt_sel_i = 3'd3; #1 chk("cnt ch3", 32'(bus.cnt_o), 32'd3);
        bus.cnt_sel_i = 3'd0; #1 chk("cnt ch0", 32'(bus.cnt_o), 32'd1);
        bus.cnt_sel_i = 3'd2; #1 chk("cnt ch2 idle", 32'(bus.cnt_o), 32'd0);

        @(negedge clk); bus.clr_cnt_i = 1'b1;
        @(negedge clk); bus.clr_cnt_i = 1'b0;
        bus.cnt_sel_i = 3'd3; #1 chk("cnt clear", 32'(bus.cnt_o), 32'd0);
        bus.cnt_sel_i = 3'd2;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk); bus.req_i = 8'h04;
        end
        @(negedge clk); bus.req_i = '0;
        #1 chk("cnt ch2 five", 32'(bus.cnt_o), 32'd5);

        @(negedge clk); bus.req_i = 8'h04; bus.clr_cnt_i = 1'b1;
        @(negedge clk); bus.req_i = '0;    bus.clr_cnt_i = 1'b0;
        #1 chk("cnt clr over inc", 32'(bus.cnt_o), 32'd0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk); bus.req_i = 8'h04;
        end
        @(negedge clk); bus.req_i = '0;
        #1 chk("cnt saturate", 32'(bus.cnt_o), 32'd7);

        // Watchdog: 15 PC stalls then release, then 16 in a row
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); bus.req_i = 8'h20;
        end
        @(negedge clk); bus.req_i = '0;
        #1 chk("wd after 15", 32'(bus.deadlock_o), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 16) begin
                #1 chk("wd 15 of 16", 32'(bus.deadlock_o), 32'd0);
            end
            bus.req_i = 8'h20;
            if (i == 1) begin
                #1 chk("wd pc stall", 32'(bus.stall_o), 32'h01);
            end
        end
        @(negedge clk); bus.req_i = '0;
        #1 chk("wd after 16", 32'(bus.deadlock_o), 32'd1);
        repeat (3) @(negedge clk);
        #1 chk("wd sticky", 32'(bus.deadlock_o), 32'd1);

        rst_n = 1'b0;
        #1;
        chk("wd reset", 32'(bus.deadlock_o), 32'd0);
        chk("reset flush", 32'(bus.flush_o), 32'h3f);
        chk("reset cnt clr", 32'(bus.cnt_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
